// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the IF/ID stage: PC sizing, jump opcodes and FSM states.
package if_id_stage_pkg;

  localparam int unsigned PC_SIZE = 5;
  localparam int unsigned PC_W    = PC_SIZE + 1;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  function automatic logic is_jump(input logic [31:0] instr);
    return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the IF/ID instruction.
module if_id_stage_hazard_detect (
  input  logic       valid,
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       stall
);

  assign stall = valid & mem_read & (ex_rt != '0) & ((ex_rt == rs) | (ex_rt == rt));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: aligns BRAM output with its PC, early J/JAL redirect,
// load-use stall with a one-entry skid, and squash of wrong-path fetches.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_W,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [INSTR_WIDTH-1:0] instruc,
  input  logic [PC_WIDTH-1:0]    PC_current,
  input  logic                   branch_taken,
  input  logic                   id_ex_mem_read,
  input  logic [4:0]             id_ex_rt,
  output logic                   PC_write,
  output logic                   jump_sel,
  output logic [PC_WIDTH-1:0]    jump_address,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus_1,
  output logic                   if_id_valid,
  output logic                   stall
);

  state_t                 state, state_d;
  logic [PC_WIDTH-1:0]    pc_d1;
  logic                   in_ok;
  logic                   skid_full;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]    skid_pc;

  logic [INSTR_WIDTH-1:0] cand_instr;
  logic [PC_WIDTH-1:0]    cand_pc;
  logic                   cand_valid;
  logic                   take_jump;

  if_id_stage_hazard_detect u_hazard (
    .valid    (if_id_valid),
    .mem_read (id_ex_mem_read),
    .ex_rt    (id_ex_rt),
    .rs       (if_id_instr[25:21]),
    .rt       (if_id_instr[20:16]),
    .stall    (stall)
  );

  // in_ok tracks the SQUASH state one edge early, so a squashed or post-reset
  // incoming word simply presents as invalid and the SQUASH cycle needs no special path.
  always_comb begin
    cand_instr = skid_full ? skid_instr : instruc;
    cand_pc    = skid_full ? skid_pc    : pc_d1;
    cand_valid = skid_full | in_ok;
    take_jump  = enable & ~branch_taken & ~stall & cand_valid & is_jump(cand_instr[31:0]);

    if (branch_taken)   state_d = ST_SQUASH;
    else if (stall)     state_d = ST_STALL;
    else if (take_jump) state_d = ST_SQUASH;
    else                state_d = ST_RUN;
  end

  assign PC_write     = ~stall;
  assign jump_sel     = take_jump;
  assign jump_address = take_jump ? cand_instr[PC_WIDTH-1:0] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_RUN;
      pc_d1           <= '0;
      in_ok           <= 1'b0;
      skid_full       <= 1'b0;
      skid_instr      <= '0;
      skid_pc         <= '0;
      if_id_instr     <= '0;
      if_id_pc_plus_1 <= '0;
      if_id_valid     <= 1'b0;
    end else if (enable) begin
      state <= state_d;
      pc_d1 <= PC_current;
      in_ok <= (state_d != ST_SQUASH);
      if (branch_taken) begin
        if_id_valid <= 1'b0;
        skid_full   <= 1'b0;
      end else if (stall) begin
        // PC is held during the stall, so only the first incoming word needs saving.
        if (state != ST_STALL && in_ok && !skid_full) begin
          skid_full  <= 1'b1;
          skid_instr <= instruc;
          skid_pc    <= pc_d1;
        end
      end else begin
        if_id_valid <= cand_valid;
        skid_full   <= 1'b0;
        if (cand_valid) begin
          if_id_instr     <= cand_instr;
          if_id_pc_plus_1 <= cand_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a small fetch/BRAM environment closing the PC loop.
module tb_if_id_stage;

  localparam int unsigned PW = 6;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [31:0]   instruc;
  logic [PW-1:0] PC_current;
  logic          branch_taken;
  logic          id_ex_mem_read;
  logic [4:0]    id_ex_rt;
  logic          PC_write;
  logic          jump_sel;
  logic [PW-1:0] jump_address;
  logic [31:0]   if_id_instr;
  logic [PW-1:0] if_id_pc_plus_1;
  logic          if_id_valid;
  logic          stall;

  logic [31:0]   mem [64];
  logic [PW-1:0] br_target;
  int            checks   = 0;
  int            failures = 0;

  if_id_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .instruc         (instruc),
    .PC_current      (PC_current),
    .branch_taken    (branch_taken),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rt        (id_ex_rt),
    .PC_write        (PC_write),
    .jump_sel        (jump_sel),
    .jump_address    (jump_address),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus_1 (if_id_pc_plus_1),
    .if_id_valid     (if_id_valid),
    .stall           (stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: fetch decisions sampled before the edge, PC/BRAM updated just after it.
  task automatic step();
    logic          js;
    logic          pw;
    logic          br;
    logic [PW-1:0] ja;
    js = jump_sel;
    ja = jump_address;
    pw = PC_write;
    br = branch_taken;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      PC_current = '0;
      instruc    = '0;
    end else if (enable) begin
      instruc = mem[PC_current];
      if (br)      PC_current = br_target;
      else if (js) PC_current = ja;
      else if (pw) PC_current = PC_current + PW'(1);
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    mem[5]  = 32'h0800_0020;  // j 0x20
    mem[33] = 32'h0109_5020;  // add rs=8
    mem[36] = 32'h0000_5020;  // add rs=0 rt=0
    mem[37] = 32'h0008_5020;  // add rt=8
    mem[49] = 32'h0109_5020;  // add rs=8

    reset_n        = 1'b0;
    enable         = 1'b1;
    branch_taken   = 1'b0;
    id_ex_mem_read = 1'b0;
    id_ex_rt       = '0;
    br_target      = '0;
    PC_current     = '0;
    instruc        = '0;
    #1;
    step();
    step();
    check("rst_pc_write", 32'(PC_write), 32'd1);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_jump_sel", 32'(jump_sel), 32'd0);
    check("rst_jump_addr", 32'(jump_address), 32'd0);
    check("rst_instr", if_id_instr, 32'd0);
    check("rst_pc1", 32'(if_id_pc_plus_1), 32'd0);

    reset_n = 1'b1;
    #1;
    check("rel_jump_sel", 32'(jump_sel), 32'd0);
    step();
    step();
    check("line_valid0", 32'(if_id_valid), 32'd1);
    check("line_pc1_0", 32'(if_id_pc_plus_1), 32'd1);
    check("line_instr0", if_id_instr, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      step();
      check($sformatf("line_pc1_%0d", k), 32'(if_id_pc_plus_1), 32'(k));
      check($sformatf("line_valid_%0d", k), 32'(if_id_valid), 32'd1);
      check($sformatf("line_pcw_%0d", k), 32'(PC_write), 32'd1);
    end

    step();
    check("jmp_sel", 32'(jump_sel), 32'd1);
    check("jmp_addr", 32'(jump_address), 32'h20);
    step();
    check("jmp_sel_after", 32'(jump_sel), 32'd0);
    check("jmp_word_valid", 32'(if_id_valid), 32'd1);
    check("jmp_word_pc1", 32'(if_id_pc_plus_1), 32'd6);
    step();
    check("jmp_bubble", 32'(if_id_valid), 32'd0);
    step();
    check("jmp_tgt_valid", 32'(if_id_valid), 32'd1);
    check("jmp_tgt_pc1", 32'(if_id_pc_plus_1), 32'h21);

    step();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd8;
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_pcw", 32'(PC_write), 32'd0);
    step();
    id_ex_mem_read = 1'b0;
    #1;
    check("lu_stall_drop", 32'(stall), 32'd0);
    check("lu_hold_instr", if_id_instr, 32'h0109_5020);
    check("lu_hold_pc1", 32'(if_id_pc_plus_1), 32'h22);
    step();
    check("lu_skid_instr", if_id_instr, 32'h22);
    check("lu_skid_pc1", 32'(if_id_pc_plus_1), 32'h23);
    step();
    check("lu_next_instr", if_id_instr, 32'h23);
    check("lu_next_pc1", 32'(if_id_pc_plus_1), 32'h24);

    step();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd0;
    #1;
    check("rt0_stall", 32'(stall), 32'd0);
    check("rt0_pcw", 32'(PC_write), 32'd1);
    id_ex_mem_read = 1'b0;

    step();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd8;
    #1;
    check("brs_stall_rt", 32'(stall), 32'd1);
    step();
    branch_taken = 1'b1;
    br_target    = 6'h30;
    #1;
    check("brs_stall", 32'(stall), 32'd1);
    check("brs_jump_sel", 32'(jump_sel), 32'd0);
    step();
    branch_taken   = 1'b0;
    id_ex_mem_read = 1'b0;
    #1;
    check("brs_bubble", 32'(if_id_valid), 32'd0);
    check("brs_jump_sel2", 32'(jump_sel), 32'd0);
    step();
    check("brs_squash", 32'(if_id_valid), 32'd0);
    step();
    check("brs_tgt_valid", 32'(if_id_valid), 32'd1);
    check("brs_tgt_pc1", 32'(if_id_pc_plus_1), 32'h31);

    step();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd8;
    #1;
    check("rs_stall", 32'(stall), 32'd1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_pcw", 32'(PC_write), 32'd1);
    check("rs_valid", 32'(if_id_valid), 32'd0);
    check("rs_pc1", 32'(if_id_pc_plus_1), 32'd0);
    step();
    reset_n        = 1'b1;
    id_ex_mem_read = 1'b0;
    #1;
    step();
    check("rs_skid_empty", 32'(if_id_valid), 32'd0);
    step();
    check("rs_first_valid", 32'(if_id_valid), 32'd1);
    check("rs_first_pc1", 32'(if_id_pc_plus_1), 32'd1);

    enable = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("frz_pc1_%0d", k), 32'(if_id_pc_plus_1), 32'd1);
      check($sformatf("frz_valid_%0d", k), 32'(if_id_valid), 32'd1);
      check($sformatf("frz_pcw_%0d", k), 32'(PC_write), 32'd1);
      check($sformatf("frz_jsel_%0d", k), 32'(jump_sel), 32'd0);
    end
    enable = 1'b1;
    #1;
    step();
    check("frz_resume_pc1", 32'(if_id_pc_plus_1), 32'd2);
    check("frz_resume_instr", if_id_instr, 32'd1);

    branch_taken = 1'b1;
    br_target    = 6'd63;
    #1;
    step();
    branch_taken = 1'b0;
    #1;
    check("wrap_bubble", 32'(if_id_valid), 32'd0);
    step();
    step();
    check("wrap_valid", 32'(if_id_valid), 32'd1);
    check("wrap_pc1", 32'(if_id_pc_plus_1), 32'd0);
    check("wrap_instr", if_id_instr, 32'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
